// File: rtl/data_mem_responder.sv
// Load/store memory responder: one request at a time, word-wide synchronous-read array,
// sign/zero-extending loads, RMW sub-word stores (direct byte-lane writes with DMEM_BYTE_WRITE_EN).
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic                  REQ_WE,
  input  logic [1:0]            REQ_SIZE,
  input  logic                  REQ_UNSIGNED,
  input  logic [31:0]           REQ_WDATA,
  output logic                  RESP_VALID,
  input  logic                  RESP_READY,
  output logic [31:0]           RESP_RDATA,
  output logic                  RESP_ERR
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_BAD  = 2'd3;

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

  state_t                state_q, state_d;
  logic                  pend_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic [31:0]           wdata_q;
  logic                  resp_valid_q;
  logic [31:0]           resp_rdata_q;
  logic                  resp_err_q;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           rd_word;

  logic                  accept;
  logic                  req_err;
  logic [3:0]            lane_be;
  logic [31:0]           lane_data;
  logic [31:0]           bit_mask;
  logic [31:0]           shifted;
  logic [31:0]           load_data;
  logic                  mem_re;
  logic                  mem_we;
  logic [31:0]           mem_wdata;
`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0]            mem_be;
`endif
  logic                  resp_set;
  logic [31:0]           resp_rdata_d;
  logic                  resp_err_d;

  wire [ADDR_WIDTH-3:0] idx = addr_q[ADDR_WIDTH-1:2];

  // A request is taken only in IDLE before it has been latched; the latched one is decoded next cycle.
  assign REQ_READY = (state_q == IDLE) && !pend_q && !RST;
  assign accept    = REQ_VALID && REQ_READY;

  assign RESP_VALID = resp_valid_q;
  assign RESP_RDATA = resp_rdata_q;
  assign RESP_ERR   = resp_err_q;

  // Request decode: error, byte lanes, lane-replicated store data and extended load data.
  always_comb begin
    req_err = (size_q == SZ_BAD) ||
              (size_q == SZ_HALF && addr_q[0]) ||
              (size_q == SZ_WORD && addr_q[1:0] != 2'b00);

    case (size_q)
      SZ_BYTE: begin
        lane_be   = 4'b0001 << addr_q[1:0];
        lane_data = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        lane_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_be   = 4'b1111;
        lane_data = wdata_q;
      end
    endcase

    for (int b = 0; b < 4; b++) begin
      bit_mask[8*b +: 8] = {8{lane_be[b]}};
    end

    shifted = rd_word >> {addr_q[1:0], 3'b000};
    case (size_q)
      SZ_BYTE: load_data = unsigned_q ? {24'b0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = unsigned_q ? {16'b0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // Next-state, array control and response capture.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    state_d      = state_q;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_wdata    = lane_data;
`ifdef DMEM_BYTE_WRITE_EN
    mem_be       = 4'b1111;
`endif
    resp_set     = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          if (req_err) begin
            state_d    = RESP;
            resp_set   = 1'b1;
            resp_err_d = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (we_q && size_q == SZ_WORD) begin
          mem_we   = 1'b1;
          state_d  = RESP;
          resp_set = 1'b1;
`ifdef DMEM_BYTE_WRITE_EN
        end else if (we_q) begin
          mem_we   = 1'b1;
          mem_be   = lane_be;
          state_d  = RESP;
          resp_set = 1'b1;
`endif
        end else begin
          mem_re  = 1'b1;
          state_d = MERGE;
        end
      end
      MERGE: begin
        state_d  = RESP;
        resp_set = 1'b1;
        if (we_q) begin
          mem_we    = 1'b1;
          mem_wdata = (rd_word & ~bit_mask) | (lane_data & bit_mask);
        end else begin
          resp_rdata_d = load_data;
        end
      end
      RESP: begin
        if (RESP_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset wins over any write due at this edge, including the RMW merge write.
    if (RST) mem_we = 1'b0;
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (RST) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept)      pend_q <= 1'b1;
      else if (pend_q) pend_q <= 1'b0;

      if (resp_set) begin
        resp_valid_q <= 1'b1;
        resp_rdata_q <= resp_rdata_d;
        resp_err_q   <= resp_err_d;
      end else if (state_q == RESP && RESP_READY) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  // NOTE: request fields and the data array hold no reset; they are always written before being used.
  always_ff @(posedge CLK) begin
    if (accept) begin
      addr_q     <= REQ_ADDR;
      we_q       <= REQ_WE;
      size_q     <= REQ_SIZE;
      unsigned_q <= REQ_UNSIGNED;
      wdata_q    <= REQ_WDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_re) rd_word <= mem[idx];
`ifdef DMEM_BYTE_WRITE_EN
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
`else
    if (mem_we) mem[idx] <= mem_wdata;
`endif
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expected responses are queued at issue and
// compared (data, error, latency) when the response handshake happens.
module tb_data_mem_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [9:0]  REQ_ADDR = '0;
  logic        REQ_WE = 1'b0;
  logic [1:0]  REQ_SIZE = 2'd0;
  logic        REQ_UNSIGNED = 1'b0;
  logic [31:0] REQ_WDATA = '0;
  logic        RESP_VALID;
  logic        RESP_READY = 1'b0;
  logic [31:0] RESP_RDATA;
  logic        RESP_ERR;

  data_mem_responder #(.ADDR_WIDTH(10)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
    .REQ_WE(REQ_WE), .REQ_SIZE(REQ_SIZE), .REQ_UNSIGNED(REQ_UNSIGNED),
    .REQ_WDATA(REQ_WDATA),
    .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY),
    .RESP_RDATA(RESP_RDATA), .RESP_ERR(RESP_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [256];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_err(input logic [1:0] size, input logic [9:0] addr);
    return size == 2'd3 || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
  endfunction

  function automatic void model_store(input logic [1:0] size, input logic [9:0] addr,
                                      input logic [31:0] wdata);
    logic [31:0] w;
    w = model[addr[9:2]];
    case (size)
      2'd0:    w[int'(addr[1:0]) * 8 +: 8] = wdata[7:0];
      2'd1:    w[int'(addr[1]) * 16 +: 16] = wdata[15:0];
      default: w = wdata;
    endcase
    model[addr[9:2]] = w;
  endfunction

  // Compute the expected response, update the model, and present the request.
  task automatic prep(input logic we, input logic [1:0] size, input logic uns,
                      input logic [9:0] addr, input logic [31:0] wdata);
    exp_t        e;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    e.rdata = '0;
    e.err   = 1'b0;
    if (is_err(size, addr)) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (we) begin
`ifdef DMEM_BYTE_WRITE_EN
      e.lat = 2;
`else
      e.lat = (size == 2'd2) ? 2 : 3;
`endif
      model_store(size, addr, wdata);
    end else begin
      e.lat = 3;
      w = model[addr[9:2]];
      b = w[int'(addr[1:0]) * 8 +: 8];
      h = w[int'(addr[1]) * 16 +: 16];
      case (size)
        2'd0:    e.rdata = uns ? {24'h0, b} : {{24{b[7]}}, b};
        2'd1:    e.rdata = uns ? {16'h0, h} : {{16{h[15]}}, h};
        default: e.rdata = w;
      endcase
    end
    sb.push_back(e);
    REQ_WE       = we;
    REQ_SIZE     = size;
    REQ_UNSIGNED = uns;
    REQ_ADDR     = addr;
    REQ_WDATA    = wdata;
    REQ_VALID    = 1'b1;
  endtask

  // Returns #1 after the accept edge.
  task automatic wait_accept(input string tag);
    int n = 0;
    while (!REQ_READY && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!REQ_READY) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
  endtask

  // Measures latency from the accept edge, optionally stalls, then completes the handshake.
  task automatic collect(input string tag, input int hold);
    exp_t        e;
    logic [31:0] held;
    int          n = 0;
    while (!RESP_VALID && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_lat"}, n, e.lat);
    check({tag, "_rdata"}, RESP_RDATA, e.rdata);
    check({tag, "_err"}, {31'b0, RESP_ERR}, {31'b0, e.err});
    held = RESP_RDATA;
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      check({tag, "_hold_valid"}, {31'b0, RESP_VALID}, 32'd1);
      check({tag, "_hold_rdata"}, RESP_RDATA, held);
      check({tag, "_hold_rdy"}, {31'b0, REQ_READY}, 32'd0);
    end
    RESP_READY = 1'b1;
    @(posedge CLK); #1;
    RESP_READY = 1'b0;
    check({tag, "_done_valid"}, {31'b0, RESP_VALID}, 32'd0);
    check({tag, "_done_rdy"}, {31'b0, REQ_READY}, 32'd1);
  endtask

  task automatic txn(input string tag, input logic we, input logic [1:0] size, input logic uns,
                     input logic [9:0] addr, input logic [31:0] wdata);
    prep(we, size, uns, addr, wdata);
    wait_accept(tag);
    collect(tag, 0);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("rst_req_ready", {31'b0, REQ_READY}, 32'd0);
    check("rst_resp_valid", {31'b0, RESP_VALID}, 32'd0);
    check("rst_resp_rdata", RESP_RDATA, 32'd0);
    check("rst_resp_err", {31'b0, RESP_ERR}, 32'd0);
    RST = 1'b0;
    #1;
    check("idle_req_ready", {31'b0, REQ_READY}, 32'd1);

    txn("sw",       1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF);
    txn("lw",       1'b0, 2'd2, 1'b0, 10'h010, 32'h0);
    txn("sb",       1'b1, 2'd0, 1'b0, 10'h011, 32'h0000007F);
    txn("lw_rmw",   1'b0, 2'd2, 1'b0, 10'h010, 32'h0);
    txn("lb13",     1'b0, 2'd0, 1'b0, 10'h013, 32'h0);
    txn("lbu13",    1'b0, 2'd0, 1'b1, 10'h013, 32'h0);
    txn("lh12",     1'b0, 2'd1, 1'b0, 10'h012, 32'h0);
    txn("lhu10",    1'b0, 2'd1, 1'b1, 10'h010, 32'h0);
    txn("lb11",     1'b0, 2'd0, 1'b0, 10'h011, 32'h0);

    txn("err_lw",   1'b0, 2'd2, 1'b0, 10'h012, 32'h0);
    txn("err_sh",   1'b1, 2'd1, 1'b0, 10'h011, 32'h00001234);
    txn("err_sz3",  1'b1, 2'd3, 1'b0, 10'h010, 32'h55555555);
    txn("lw_after", 1'b0, 2'd2, 1'b0, 10'h010, 32'h0);

    txn("sw20",     1'b1, 2'd2, 1'b0, 10'h020, 32'h11223344);
    txn("sh22",     1'b1, 2'd1, 1'b0, 10'h022, 32'hFFFFA5A5);
    txn("sb20",     1'b1, 2'd0, 1'b0, 10'h020, 32'hFFFFFF80);
    txn("lw20",     1'b0, 2'd2, 1'b0, 10'h020, 32'h0);
    txn("lb20",     1'b0, 2'd0, 1'b0, 10'h020, 32'h0);
    txn("lhu22",    1'b0, 2'd1, 1'b1, 10'h022, 32'h0);

    // Backpressure: a second request waits behind a stalled response.
    prep(1'b0, 2'd2, 1'b0, 10'h010, 32'h0);
    wait_accept("bp");
    prep(1'b0, 2'd0, 1'b1, 10'h012, 32'h0);
    collect("bp", 5);
    wait_accept("bp_next");
    collect("bp_next", 0);

    // Reset while the RMW store of byte 0x00 to 0x010 sits in MERGE.
    REQ_WE = 1'b1; REQ_SIZE = 2'd0; REQ_UNSIGNED = 1'b0;
    REQ_ADDR = 10'h010; REQ_WDATA = 32'h0;
    REQ_VALID = 1'b1;
    wait_accept("rmw_rst");
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    check("rmw_rst_rdy_in_rst", {31'b0, REQ_READY}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    check("rmw_rst_valid", {31'b0, RESP_VALID}, 32'd0);
    check("rmw_rst_rdy", {31'b0, REQ_READY}, 32'd1);
`ifdef DMEM_BYTE_WRITE_EN
    model_store(2'd0, 10'h010, 32'h0);
`endif
    txn("lw_post_rst", 1'b0, 2'd2, 1'b0, 10'h010, 32'h0);

    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the executer's load/store memory interface.
- Accepts one request at a time over a valid/ready handshake and owns a word-wide synchronous-read data array.
- Performs word, halfword and byte loads with sign/zero extension, and word, halfword and byte stores. Sub-word stores use read-modify-write.
- Returns read data or an error on a separate valid/ready response channel. Sits between the executer and writeback.

Parameters:
- ADDR_WIDTH, 10, byte-address width. The array holds 2**(ADDR_WIDTH-2) 32-bit words.

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  reset; synchronous, active-high
- REQ_VALID  input  1  request present
- REQ_READY  output  1  responder can accept a request
- REQ_ADDR  input  ADDR_WIDTH  byte address
- REQ_WE  input  1  1 = store, 0 = load
- REQ_SIZE  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- REQ_UNSIGNED  input  1  load zero-extends (lbu/lhu); ignored for stores
- REQ_WDATA  input  32  store data, right-aligned
- RESP_VALID  output  1  response present
- RESP_READY  input  1  consumer accepts response
- RESP_RDATA  output  32  extended load data; 0 for stores and errors
- RESP_ERR  output  1  misaligned or illegal-size request

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE; RESP_VALID=0, RESP_RDATA=0, RESP_ERR=0.
  - REQ_READY=0 while RST=1. Array contents are not reset.
  - RST has priority over every other event. A write scheduled at the same edge is suppressed, including the merge write of an in-flight RMW. Any pending response is dropped.
- States: IDLE, ACCESS, MERGE, RESP.
- IDLE:
  - REQ_READY=1. A request is accepted on the edge where REQ_VALID && REQ_READY.
  - All request fields are latched at that edge.
  - Error check on latched fields: SIZE=3, half with addr[0]=1, or word with addr[1:0]!=0.
  - Error -> RESP with ERR=1, RDATA=0, no array access.
  - Otherwise -> ACCESS.
- ACCESS:
  - Word index = addr[ADDR_WIDTH-1:2].
  - Word store: write REQ_WDATA at this edge -> RESP.
  - Load: issue array read -> MERGE.
  - Sub-word store: issue array read -> MERGE. With DMEM_BYTE_WRITE_EN defined, a sub-word store instead writes its byte lanes directly -> RESP.
- MERGE (read data valid this cycle):
  - Load: select the lane by addr[1:0] (byte) or addr[1] (half), sign- or zero-extend, register into RESP_RDATA -> RESP.
  - Sub-word store: replace the addressed byte/half of the read word with REQ_WDATA[7:0] or [15:0], write at this edge -> RESP with RDATA=0.
- RESP:
  - RESP_VALID=1; RDATA and ERR are held stable until RESP_VALID && RESP_READY -> IDLE.
  - REQ_READY=0 throughout. No new request is accepted in the handshake cycle; the next accept is no earlier than the following cycle.
- Latency from the accept edge E0 to RESP_VALID high:
  - Error: 1 cycle (visible after E1).
  - Word store: 2 cycles.
  - Load: 3 cycles.
  - RMW store: 3 cycles.
- Response-only outputs RESP_VALID, RESP_RDATA and RESP_ERR are registered. REQ_READY is decoded from state and RST.
- At most one request is outstanding. Back-to-back requests to the same word observe the prior write, because the write completes before RESP.
- Address wrap: the index uses only ADDR_WIDTH bits; there is no out-of-range error.

Optional Feature:
- Macro: DMEM_BYTE_WRITE_EN.
- Defined: the array has 4 per-byte write enables. Sub-word stores skip MERGE, so every store has 2-cycle latency and the array is never read for a store.
- Undefined: single word write enable. Sub-word stores use read-modify-write via MERGE (3-cycle latency).
- Load behaviour, errors and the response protocol are identical in both builds.

Test Plan:
- Store word: addr 0x010, data 0xDEADBEEF; then load word 0x010 -> RDATA=0xDEADBEEF, ERR=0. Store response has RDATA=0 and arrives 2 cycles after accept; load response arrives 3 cycles after accept.
- Store byte 0x7F to 0x011 over word 0xDEADBEEF; load word 0x010 -> 0xDEAD7FEF.
- Sign/zero extension: load byte 0x013 signed -> 0xFFFFFFDE, unsigned -> 0x000000DE. Load half 0x012 signed -> 0xFFFFDEAD.
- Misaligned: load word at 0x012, store half at 0x011, SIZE=3 -> ERR=1, RDATA=0 each time. RESP_VALID arrives 1 cycle after accept, and a word read at the target afterwards is unchanged.
- Backpressure: hold RESP_READY=0 for 5 cycles after RESP_VALID. RESP_VALID and RDATA stay constant, REQ_READY=0 throughout, and a pending REQ_VALID is not accepted until the cycle after the response handshake.
- Reset mid-RMW: start a store byte 0x00 to 0x010 and assert RST for 1 cycle in MERGE. The word stays unchanged, RESP_VALID=0, and REQ_READY=1 the cycle after RST deasserts.
